// File: rtl/instr_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package instr_prefetch_queue_pkg;

    localparam int PFQ_XLEN    = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        PFQ_IDLE    = 2'd0,
        PFQ_REQ     = 2'd1,
        PFQ_DISCARD = 2'd2
    } pfq_state_t;

    typedef struct packed {
        logic [PFQ_XLEN-1:0] pc;
        logic [PFQ_XLEN-1:0] instr;
    } pfq_entry_t;

endpackage

// File: rtl/instr_prefetch_queue_fifo.sv
// Generic DEPTH-entry synchronous FIFO with push/pop/clear and an occupancy count.
module pfq_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO is only legal when a pop frees a slot the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch front-end: one outstanding memory read feeding a {pc, instr} FIFO,
// flushed on redirect. Define PFQ_BYPASS_EN to forward a response straight to an empty queue's outputs.
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ADDR_W   = 25,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   mem_instr_enable,
    output logic [ADDR_W-1:0]      mem_instr_addr,
    input  logic                   mem_instr_valid,
    input  logic [XLEN-1:0]        mem_instr_result,
    output logic                   fetch_valid,
    input  logic                   fetch_ready,
    output logic [XLEN-1:0]        fetch_instr,
    output logic [XLEN-1:0]        fetch_pc,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int              CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

    pfq_state_t        r_state;
    pfq_state_t        w_state_next;
    logic [XLEN-1:0]   r_next_pc;
    logic [XLEN-1:0]   r_req_pc;
    logic              r_enable;
    logic [ADDR_W-1:0] r_addr;

    logic              w_issue;
    logic              w_accept;
    logic              w_bypass;
    logic              w_pop;
    logic              w_fifo_push;
    logic              w_fifo_pop;
    logic              w_fifo_empty;
    logic [2*XLEN-1:0] w_head;
    logic [XLEN-1:0]   w_head_pc;
    logic [XLEN-1:0]   w_head_instr;
    logic [CNT_W-1:0]  w_count;
    logic              w_has_room;

    // A slot is reserved at issue, so a pop in the same cycle makes room for the next request.
    assign w_has_room = (w_count != CNT_W'(DEPTH)) || w_pop;

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            PFQ_IDLE: begin
                if (!redirect && w_has_room) begin
                    w_issue      = 1'b1;
                    w_state_next = PFQ_REQ;
                end
            end
            PFQ_REQ: begin
                if (mem_instr_valid) begin
                    w_accept     = !redirect;
                    w_state_next = PFQ_IDLE;
                end else if (redirect) begin
                    w_state_next = PFQ_DISCARD;
                end
            end
            PFQ_DISCARD: begin
                if (mem_instr_valid) begin
                    w_state_next = PFQ_IDLE;
                end
            end
            default: w_state_next = PFQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= PFQ_IDLE;
            r_next_pc <= RESET_PC;
            r_req_pc  <= RESET_PC;
            r_enable  <= 1'b0;
            r_addr    <= RESET_PC[ADDR_W-1:0];
        end else begin
            r_state <= w_state_next;
            if (w_issue) begin
                r_enable <= 1'b1;
                r_addr   <= r_next_pc[ADDR_W-1:0];
                r_req_pc <= r_next_pc;
            end else if (mem_instr_valid && (r_state != PFQ_IDLE)) begin
                r_enable <= 1'b0;
            end
            if (redirect) begin
                r_next_pc <= redirect_pc;
            end else if (w_issue) begin
                r_next_pc <= r_next_pc + PC_STEP;
            end
        end
    end

`ifdef PFQ_BYPASS_EN
    assign w_bypass = w_fifo_empty && (r_state == PFQ_REQ) && mem_instr_valid && !redirect;
`else
    assign w_bypass = 1'b0;
`endif

    // A redirect flushes the queue, so a simultaneous handshake must not advance it.
    assign w_pop       = fetch_valid && fetch_ready && !redirect;
    assign w_fifo_pop  = w_pop && !w_fifo_empty;
    assign w_fifo_push = w_accept && !(w_bypass && fetch_ready);

    pfq_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fifo_push),
        .i_pop   (w_fifo_pop),
        .i_clear (redirect),
        .i_wdata ({r_req_pc, mem_instr_result}),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_empty (w_fifo_empty)
    );

    assign w_head_pc    = w_head[2*XLEN-1:XLEN];
    assign w_head_instr = w_head[XLEN-1:0];

    always_comb begin
        fetch_valid = !w_fifo_empty;
        fetch_pc    = w_fifo_empty ? '0 : w_head_pc;
        fetch_instr = w_fifo_empty ? '0 : w_head_instr;
        if (w_bypass) begin
            fetch_valid = 1'b1;
            fetch_pc    = r_req_pc;
            fetch_instr = mem_instr_result;
        end
    end

    assign mem_instr_enable = r_enable;
    assign mem_instr_addr   = r_addr;
    assign occupancy        = w_count;

endmodule
